// File: rtl/instruction_fetch.sv
// Instruction fetch: single-outstanding memory requester feeding a 2-entry
// {pc, word} buffer, with redirect support that discards wrong-path fetches.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   typedef enum logic {RUN, DROP} state_t;

   state_t           state_q, state_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [31:0]      pend_pc_q, pend_pc_d;
   logic [1:0]       count_q, count_d;
   logic [1:0][31:0] pc_q, pc_d;
   logic [1:0][31:0] word_q, word_d;

   logic        push, pop;
   logic [31:0] redir_al;

   assign redir_al    = {redirect_pc[31:2], 2'b00};
   assign mem_req     = !reset && ((state_q == RUN && count_q != 2'd2) || state_q == DROP);
   assign mem_addr    = fetch_pc_q;
   assign instr_valid = !reset && (count_q != 2'd0);
   assign instruction = word_q[0];
   assign instr_pc    = pc_q[0];

   assign push = (state_q == RUN) && mem_req && mem_ack && !redirect;
   assign pop  = instr_valid && instr_ready;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      pend_pc_d  = pend_pc_q;
      count_d    = count_q;
      pc_d       = pc_q;
      word_d     = word_q;

      // A pop in a redirect cycle is still delivered; everything else is flushed.
      if (redirect) begin
         count_d = 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count_q == 2'd0) begin
                  pc_d[0] = fetch_pc_q;
                  word_d[0] = mem_rdata;
               end else begin
                  pc_d[1] = fetch_pc_q;
                  word_d[1] = mem_rdata;
               end
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               pc_d[0]   = pc_q[1];
               word_d[0] = word_q[1];
               count_d   = count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd2) begin
                  pc_d[0]   = pc_q[1];
                  word_d[0] = word_q[1];
                  pc_d[1]   = fetch_pc_q;
                  word_d[1] = mem_rdata;
               end else begin
                  pc_d[0]   = fetch_pc_q;
                  word_d[0] = mem_rdata;
               end
            end
            default: ;
         endcase
      end

      case (state_q)
         RUN: begin
            if (redirect) begin
               // An unacked request cannot be withdrawn; wait it out in DROP.
               if (mem_req && !mem_ack) begin
                  pend_pc_d = redir_al;
                  state_d   = DROP;
               end else begin
                  fetch_pc_d = redir_al;
               end
            end else if (push) begin
               fetch_pc_d = fetch_pc_q + 32'd4;
            end
         end
         DROP: begin
            if (mem_ack) begin
               fetch_pc_d = redirect ? redir_al : pend_pc_q;
               state_d    = RUN;
            end else if (redirect) begin
               pend_pc_d = redir_al;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RUN;
         fetch_pc_q <= RESET_PC;
         count_q    <= 2'd0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         pend_pc_q  <= pend_pc_d;
         count_q    <= count_d;
         pc_q       <= pc_d;
         word_q     <= word_d;
      end
   end

endmodule
